// File: rtl/square_disp_pkg.sv
// Shared definitions for the squared-value display: FSM encoding, 7-segment
// patterns ({g,f,e,d,c,b,a}, active high) and the double-dabble step.
package square_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CONV_STEPS = 6;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Layout {tens, ones, binary}: correct each BCD nibble, then shift left.
    function automatic logic [13:0] dabble_step(input logic [13:0] r);
        logic [3:0] t;
        logic [3:0] o;
        t = r[13:10];
        o = r[9:6];
        if (t >= 4'd5) t = t + 4'd3;
        if (o >= 4'd5) o = o + 4'd3;
        return {t, o, r[5:0]} << 1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment map; codes 10..15 show blank.
module seg7_decode
    import square_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/square_display.sv
// Converts a 6-bit squared value to two BCD digits by double-dabble and
// multiplexes them onto a two-digit common 7-segment display.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for load; value captured when load is high
// ST_CONV | one double-dabble step per cycle, six steps total
// ST_DONE | commit tens/ones, pulse done, return to idle
module square_display
    import square_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] value,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int CW = $clog2(SCAN_DIV);

    state_t      state;
    state_t      state_nxt;
    logic [13:0] dd_reg;
    logic [2:0]  step_cnt;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (load) state_nxt = ST_CONV;
            ST_CONV: if (step_cnt == 3'(CONV_STEPS - 1)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // value is only sampled in idle, so changes mid-conversion are harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            dd_reg   <= '0;
            step_cnt <= '0;
            tens     <= '0;
            ones     <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        dd_reg   <= {8'd0, value};
                        step_cnt <= '0;
                    end
                end
                ST_CONV: begin
                    dd_reg   <= dabble_step(dd_reg);
                    step_cnt <= step_cnt + 3'd1;
                end
                ST_DONE: begin
                    tens <= dd_reg[13:10];
                    ones <= dd_reg[9:6];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [CW-1:0] scan_cnt;
    logic          scan_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_sel <= 1'b0;
        end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_sel <= ~scan_sel;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    logic [3:0] digit_sel;
    logic [6:0] seg_raw;
    logic       blank;

    assign digit_sel = scan_sel ? tens : ones;
    assign blank     = scan_sel && (BLANK_LZ != 0) && (tens == 4'd0);

    seg7_decode u_dec (
        .digit (digit_sel),
        .seg   (seg_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 2'b01;
            seg <= SEG_0;
        end else begin
            an  <= scan_sel ? 2'b10 : 2'b01;
            seg <= blank ? SEG_BLANK : seg_raw;
        end
    end

endmodule

// File: tb/tb_square_display.sv
// Directed bench for square_display with a short scan period (SCAN_DIV=4).
module tb_square_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [5:0] value;
    logic       busy;
    logic       done;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg;
    logic [1:0] an;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] P0 = 7'b0111111;
    localparam logic [6:0] P4 = 7'b1100110;
    localparam logic [6:0] P9 = 7'b1101111;
    localparam logic [6:0] PB = 7'b0000000;

    square_display #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (value),
        .busy  (busy),
        .done  (done),
        .tens  (tens),
        .ones  (ones),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load v, then follow the conversion cycle by cycle.
    task automatic convert_check(input logic [5:0] v, input logic [3:0] et, input logic [3:0] eo,
                                 input logic [3:0] old_t, input logic [3:0] old_o);
        load  = 1'b1;
        value = v;
        tick();
        load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("conv_busy", busy, 1'b1);
            check("conv_no_done", done, 1'b0);
            check("conv_tens_hold", tens, old_t);
            check("conv_ones_hold", ones, old_o);
            tick();
        end
        check("end_busy", busy, 1'b0);
        check("end_done", done, 1'b1);
        check("end_tens", tens, et);
        check("end_ones", ones, eo);
        tick();
        check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int done_cnt;
        int found;
        logic [1:0] cur_an;
        logic [1:0] exp_an;

        rst   = 1'b1;
        load  = 1'b0;
        value = 6'd0;
        tick();
        load  = 1'b1;
        value = 6'd20;
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tens", tens, 4'd0);
        check("rst_ones", ones, 4'd0);
        check("rst_an", an, 2'b01);
        check("rst_seg", seg, P0);
        rst  = 1'b0;
        load = 1'b0;
        tick();
        check("rst_prio_idle", busy, 1'b0);

        convert_check(6'd49, 4'd4, 4'd9, 4'd0, 4'd0);

        // Digits 4/9 on display: tens shows '4' (not blanked).
        for (int i = 0; i < 10; i++) begin
            tick();
            if (an == 2'b01) check("seg49_ones", seg, P9);
            else begin
                check("an49_tens", an, 2'b10);
                check("seg49_tens", seg, P4);
            end
        end

        convert_check(6'd0, 4'd0, 4'd0, 4'd4, 4'd9);
        convert_check(6'd10, 4'd1, 4'd0, 4'd0, 4'd0);
        convert_check(6'd63, 4'd6, 4'd3, 4'd1, 4'd0);

        // Load while busy is ignored.
        load  = 1'b1;
        value = 6'd36;
        tick();
        load = 1'b0;
        tick();
        tick();
        load  = 1'b1;
        value = 6'd1;
        tick();
        load  = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("lwb_done_count", done_cnt, 1);
        check("lwb_tens", tens, 4'd3);
        check("lwb_ones", ones, 4'd6);

        // Scan and leading-zero blanking on value 9.
        convert_check(6'd9, 4'd0, 4'd9, 4'd3, 4'd6);
        cur_an = an;
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            tick();
            if (an != cur_an) found = 1;
        end
        check("scan_toggle_seen", found, 1);
        cur_an = an;
        for (int k = 0; k < 16; k++) begin
            exp_an = ((k / 4) % 2 == 0) ? cur_an : ~cur_an;
            check("scan_an", an, exp_an);
            check("scan_seg", seg, (exp_an == 2'b01) ? P9 : PB);
            tick();
        end

        // Reset in the middle of a conversion.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load  = 1'b1;
        value = 6'd25;
        tick();
        load = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_tens", tens, 4'd0);
        check("abort_ones", ones, 4'd0);

        // Back-to-back loads: done every 8 cycles.
        load  = 1'b1;
        value = 6'd63;
        for (int i = 0; i < 28; i++) begin
            tick();
            check("b2b_done", done, (i % 8) == 7);
        end
        load = 1'b0;
        check("b2b_tens", tens, 4'd6);
        check("b2b_ones", ones, 4'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/square_display.md
SQUARE_DISPLAY -- requirements
Module: square_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clk cycles per digit-scan slot; legal range 2..2^20.
REQ-002 SHALL have parameter BLANK_LZ, default 1, meaning the tens digit is blanked when it is 0.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 SHALL have port load, input, 1, a request to capture value; sampled only in IDLE.
REQ-006 SHALL have port value, input, 6, the squared number from the upstream squarer (0..49 nominal; 0..63 legal).
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse when the new digits are committed.
REQ-009 SHALL have port tens, output, 4, the committed BCD tens digit.
REQ-010 SHALL have port ones, output, 4, the committed BCD ones digit.
REQ-011 SHALL have port seg, output, 7, the active-high segments {g,f,e,d,c,b,a}.
REQ-012 SHALL have port an, output, 2, the active-high digit enables; an[0] = ones and an[1] = tens.

Function
REQ-013 SHALL implement FSM states IDLE, CONV and DONE; busy = (state != IDLE).
REQ-014 SHALL, when IDLE with load=1 at edge N, load value into the shift register, clear the BCD scratch and the step counter, and enter CONV.
REQ-015 SHALL perform one double-dabble step per edge in CONV: first add 3 to each BCD nibble >= 5, then shift left by one; the six steps occur at edges N+1..N+6, and the FSM enters DONE at edge N+6.
REQ-016 SHALL, at edge N+7 in DONE, update tens and ones, assert done for exactly the following cycle, and return to IDLE.
REQ-017 SHALL keep busy high from edge N to edge N+7 (7 cycles); a new load is accepted at edge N+8 at the earliest.
REQ-018 SHALL ignore load while busy; value changes during CONV SHALL NOT affect the result.
REQ-019 SHALL NOT change tens and ones at any time other than DONE or reset.
REQ-020 SHALL run the scan counter from 0 to SCAN_DIV-1 and toggle the digit select on wrap, independent of the FSM.
REQ-021 SHALL drive an = 2'b01 with seg = decode(ones) when select = 0, and an = 2'b10 with seg = decode(tens) when select = 1; exactly one an bit is high at a time.
REQ-022 SHALL decode digits 0-9 to the standard patterns (for example '0' = 7'b0111111, '1' = 7'b0000110) and 10-15 to blank (7'b0000000).
REQ-023 SHALL output seg = 7'b0000000 while the tens digit is selected, if BLANK_LZ=1 and tens=0.
REQ-024 SHALL register seg and an, so they change one cycle after the select changes.

Reset
REQ-025 SHALL, on rst=1 at an edge, set state=IDLE, busy=0, done=0, tens=0, ones=0, scan counter=0, select=0, an=2'b01, seg=7'b0111111.
REQ-026 SHALL abort an in-progress conversion on reset mid-operation, with no done pulse and no digit update.
REQ-027 SHALL give rst priority over load in the same cycle.

Structure
REQ-028 SHALL place the FSM state encoding, the 7-segment pattern constants and the blank code in the shared package square_disp_pkg.
REQ-029 SHALL implement the combinational BCD-to-segment map as sub-module seg7_decode (4-bit in, 7-bit out), instantiated once on the selected digit.
REQ-030 SHALL size the scan counter at $clog2(SCAN_DIV) bits.

Verification
REQ-031 SHALL cover reset: rst for 2 cycles -> tens=0, ones=0, busy=0, an=01, seg=0111111.
REQ-032 SHALL cover a conversion: load=1 with value=49 at edge N -> busy high for 7 cycles, done high one cycle after edge N+7, tens=4, ones=9.
REQ-033 SHALL cover load while busy: load 36, then load value=1 at N+3 -> result tens=3, ones=6, and exactly one done pulse.
REQ-034 SHALL cover scan and blanking with SCAN_DIV=4: convert 9 -> an alternates 01/10 every 4 cycles, seg=1101111 on ones, seg=0000000 on tens.
REQ-035 SHALL cover reset mid-conversion: rst at N+4 during a load of 25 -> busy=0 the next cycle, no done, digits remain 0.
REQ-036 SHALL cover back-to-back loads: load held high with value=63 -> a done pulse every 8 cycles, tens=6, ones=3.
